// File: rtl/mmm_mb_precompute_if.sv
// ============================================================================
// Module      : mmm_mb_precompute_if
// Description : Start/done handshake and operand/result bus for the mb
//               precompute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmm_mb_precompute_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] m_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             mb_valid;
  logic [WIDTH:0]   mb_out;

  modport master (
    output start, m_in, b_in,
    input  busy, done, mb_valid, mb_out
  );

  modport slave (
    input  start, m_in, b_in,
    output busy, done, mb_valid, mb_out
  );
endinterface

`default_nettype wire

// File: rtl/mmm_mb_precompute.sv
// ============================================================================
// Module      : mmm_mb_precompute
// Description : Bit-serial mb = m + b precompute (WIDTH+1 bits, LSB first)
//               feeding the mbi inputs of the PE mux array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmm_mb_precompute #(
  parameter int WIDTH = 8
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  mmm_mb_precompute_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_m_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_mb_valid;
  logic [WIDTH:0]   r_mb;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_unused_acc0;

  assign w_sum         = r_m_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_cout        = (r_m_sr[0] & r_b_sr[0]) | (r_m_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_acc_next    = {w_sum, r_acc[WIDTH-1:1]};
  assign w_unused_acc0 = r_acc[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_m_sr     <= '0;
      r_b_sr     <= '0;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mb_valid <= 1'b0;
      r_mb       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_m_sr     <= bus.m_in;
            r_b_sr     <= bus.b_in;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_mb_valid <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_ADD;
          end
        end
        S_ADD: begin
          r_m_sr  <= {1'b0, r_m_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_mb       <= {w_cout, w_acc_next};
            r_mb_valid <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.mb_valid = r_mb_valid;
  assign bus.mb_out   = r_mb;

endmodule

`default_nettype wire
